circle_raster: RTL and testbench

CIRCLE_RASTER -- requirements
Module: circle_raster

---
 rtl/circle_raster.sv | 186 ++++++++++++++++++
 tb/tb_circle_raster.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/circle_raster.sv
// circle_raster
// Midpoint circle rasteriser that streams framebuffer writes, one octant
// point per clock.
//
// Parameters
//   H_RES, V_RES : visible framebuffer size in pixels / lines
// Ports
//   clk          : clock, all state changes on its rising edge
//   rst_n        : synchronous active-low reset
//   start        : draw request, only looked at while idle
//   cx, cy       : circle center in pixels
//   radius       : circle radius in pixels
//   color        : RGB888 draw color
//   busy         : high whenever a circle is being drawn or finishing
//   done         : one-cycle pulse when a circle is complete
//   writing      : framebuffer write strobe
//   waddr, wdata : framebuffer write address (y*H_RES+x) and data
//
// All outputs are registers. Each clock edge computes the point for the
// slot the machine is about to enter, so the strobe and address appear in
// the same cycle that the slot is consumed.

module circle_raster #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  cx,
  input  logic [8:0]  cy,
  input  logic [9:0]  radius,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic        writing,
  output logic [18:0] waddr,
  output logic [23:0] wdata
);

  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

  localparam logic signed [13:0] HLIM   = 14'(H_RES);
  localparam logic signed [13:0] VLIM   = 14'(V_RES);
  localparam logic [18:0]        HRES_W = 19'(H_RES);

  state_t             state;
  logic [2:0]         k;
  logic signed [13:0] x, y, err;
  logic [9:0]         cx_q;
  logic [8:0]         cy_q;
  logic [23:0]        color_q;

  // One midpoint step, applied when the eighth slot of an iteration retires.
  logic signed [13:0] x_upd, y_upd, err_upd;

  always_comb begin
    y_upd   = y + 14'sd1;
    x_upd   = x;
    err_upd = err + (y_upd <<< 1) + 14'sd1;
    if (!err[13]) begin
      x_upd   = x - 14'sd1;
      err_upd = err + ((y_upd - x_upd) <<< 1) + 14'sd1;
    end
  end

  // Octant state for the slot that will be current after this edge. From
  // IDLE this is slot 0 of a fresh circle taken straight from the inputs.
  logic signed [13:0] nx, ny, nerr;
  logic [2:0]         nk;
  logic [9:0]         ncx;
  logic [8:0]         ncy;

  always_comb begin
    nx   = x;
    ny   = y;
    nerr = err;
    nk   = k + 3'd1;
    ncx  = cx_q;
    ncy  = cy_q;
    if (state == IDLE) begin
      nx   = $signed({4'b0, radius});
      ny   = '0;
      nerr = 14'sd1 - $signed({4'b0, radius});
      nk   = 3'd0;
      ncx  = cx;
      ncy  = cy;
    end else if (k == 3'd7) begin
      nx   = x_upd;
      ny   = y_upd;
      nerr = err_upd;
      nk   = 3'd0;
    end
  end

  // Map the slot onto one of the eight symmetric points and clip it.
  // Negative coordinates are caught by the sign bit; the address uses the
  // low bits only, which are exact whenever the point is on screen.
  logic signed [13:0] dx, dy, px, py;
  logic               on_screen;
  logic [18:0]        addr;

  always_comb begin
    dx = nx;
    dy = ny;
    case (nk)
      3'd0:    begin dx =  nx; dy =  ny; end
      3'd1:    begin dx =  ny; dy =  nx; end
      3'd2:    begin dx = -ny; dy =  nx; end
      3'd3:    begin dx = -nx; dy =  ny; end
      3'd4:    begin dx = -nx; dy = -ny; end
      3'd5:    begin dx = -ny; dy = -nx; end
      3'd6:    begin dx =  ny; dy = -nx; end
      default: begin dx =  nx; dy = -ny; end
    endcase
    px        = $signed({4'b0, ncx}) + dx;
    py        = $signed({5'b0, ncy}) + dy;
    on_screen = !px[13] && !py[13] && (px < HLIM) && (py < VLIM);
    addr      = 19'(py[12:0]) * HRES_W + 19'(px[12:0]);
  end

  // Control FSM. Strobe and done default low so each is a single-cycle
  // event; waddr only moves on real writes so clipped slots leave it quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      x       <= '0;
      y       <= '0;
      err     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      writing <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      done    <= 1'b0;
      writing <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cx_q    <= cx;
            cy_q    <= cy;
            color_q <= color;
            x       <= nx;
            y       <= ny;
            err     <= nerr;
            k       <= nk;
            state   <= PLOT;
            busy    <= 1'b1;
            writing <= on_screen;
            wdata   <= color;
            if (on_screen) waddr <= addr;
          end
        end
        PLOT: begin
          if (k == 3'd7 && x_upd < y_upd) begin
            state <= DONE;
            done  <= 1'b1;
            k     <= 3'd0;
          end else begin
            x       <= nx;
            y       <= ny;
            err     <= nerr;
            k       <= nk;
            writing <= on_screen;
            wdata   <= color_q;
            if (on_screen) waddr <= addr;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_raster.sv
// tb_circle_raster
// Self-checking bench for circle_raster. A plain-integer midpoint model
// builds the expected per-cycle write stream for each circle; a table of
// named circles also carries hand-derived cycle/write totals.

module tb_circle_raster;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cx = '0;
  logic [8:0]  cy = '0;
  logic [9:0]  radius = '0;
  logic [23:0] color = '0;
  logic        busy, done, writing;
  logic [18:0] waddr;
  logic [23:0] wdata;

  int total = 0;
  int bad   = 0;

  circle_raster #(.H_RES(640), .V_RES(480)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cx(cx), .cy(cy),
    .radius(radius), .color(color), .busy(busy), .done(done),
    .writing(writing), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wr;
    int addr;
  } pix_t;

  typedef struct {
    int          cx;
    int          cy;
    int          r;
    logic [23:0] col;
    int          disturb;
    int          cycles;
    int          writes;
    int          first_addr;
  } vec_t;

  pix_t expq[$];

  // Reference: the midpoint algorithm in plain ints, one entry per slot.
  task automatic buildModel(input int ccx, input int ccy, input int r);
    int x, y, err, px, py;
    pix_t p;
    expq.delete();
    x = r; y = 0; err = 1 - r;
    do begin
      for (int s = 0; s < 8; s++) begin
        case (s)
          0: begin px = ccx + x; py = ccy + y; end
          1: begin px = ccx + y; py = ccy + x; end
          2: begin px = ccx - y; py = ccy + x; end
          3: begin px = ccx - x; py = ccy + y; end
          4: begin px = ccx - x; py = ccy - y; end
          5: begin px = ccx - y; py = ccy - x; end
          6: begin px = ccx + y; py = ccy - x; end
          default: begin px = ccx + x; py = ccy - y; end
        endcase
        p.wr   = (px >= 0 && px < 640 && py >= 0 && py < 480);
        p.addr = p.wr ? py * 640 + px : 0;
        expq.push_back(p);
      end
      y++;
      if (err < 0) err += 2 * y + 1;
      else begin
        x--;
        err += 2 * (y - x) + 1;
      end
    end while (x >= y);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at the negedge of the first PLOT cycle; returns at the negedge
  // where done is seen (or the cycle budget runs out).
  task automatic drainCircle(input logic [23:0] col, input int disturb,
                             output int cycles, output int writes,
                             output int first_addr);
    cycles = 0; writes = 0; first_addr = -1;
    while (done !== 1'b1 && cycles < 4000) begin
      if (cycles == disturb) begin
        start  = 1'b1;
        cx     = 10'($urandom);
        cy     = 9'($urandom);
        radius = 10'($urandom_range(0, 30));
        color  = 24'($urandom);
      end else if (cycles == disturb + 1) begin
        start = 1'b0;
      end
      if (cycles < expq.size()) begin
        checkOutput("busy_plot", int'(busy), 1);
        checkOutput("writing", int'(writing), int'(expq[cycles].wr));
        if (expq[cycles].wr) begin
          checkOutput("waddr", int'(waddr), expq[cycles].addr);
          checkOutput("wdata", int'(wdata), int'(col));
        end
      end
      if (writing === 1'b1) begin
        writes++;
        if (first_addr < 0) first_addr = int'(waddr);
      end
      cycles++;
      @(negedge clk);
    end
    checkOutput("done_seen", int'(done === 1'b1), 1);
    checkOutput("done_no_write", int'(writing), 0);
    checkOutput("plot_cycles", cycles, expq.size());
  endtask

  task automatic applyStimulus(input int ccx, input int ccy, input int r,
                               input logic [23:0] col, input int disturb,
                               output int cycles, output int writes,
                               output int first_addr);
    buildModel(ccx, ccy, r);
    @(negedge clk);
    cx = 10'(ccx); cy = 9'(ccy); radius = 10'(r); color = col;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drainCircle(col, disturb, cycles, writes, first_addr);
    start = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int cyc, wr, fa, dcount, wcount;
    logic [23:0] rc;

    vecs[0] = '{cx: 100, cy: 50,  r: 0, col: 24'hFF0000, disturb: -1, cycles: 8,  writes: 8,  first_addr: 32100};
    vecs[1] = '{cx: 10,  cy: 10,  r: 1, col: 24'h00FF00, disturb: -1, cycles: 8,  writes: 8,  first_addr: 6411};
    vecs[2] = '{cx: 320, cy: 240, r: 3, col: 24'h0000FF, disturb: -1, cycles: 24, writes: 24, first_addr: 153923};
    vecs[3] = '{cx: 0,   cy: 0,   r: 5, col: 24'h123456, disturb: -1, cycles: 32, writes: 10, first_addr: 5};
    vecs[4] = '{cx: 200, cy: 100, r: 4, col: 24'hABCDEF, disturb: 5,  cycles: 32, writes: 32, first_addr: 64204};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_writing", int'(writing), 0);
    checkOutput("rst_waddr", int'(waddr), 0);
    checkOutput("rst_wdata", int'(wdata), 0);
    rst_n = 1'b1;

    // Named circles, including a start pulse while busy
    foreach (vecs[i]) begin
      $display("[TB] circle r=%0d at (%0d,%0d)", vecs[i].r, vecs[i].cx, vecs[i].cy);
      applyStimulus(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].col,
                    vecs[i].disturb, cyc, wr, fa);
      checkOutput("tbl_cycles", cyc, vecs[i].cycles);
      checkOutput("tbl_writes", wr, vecs[i].writes);
      checkOutput("tbl_first_addr", fa, vecs[i].first_addr);
      @(negedge clk);
      checkOutput("post_busy", int'(busy), 0);
      checkOutput("post_single_done", int'(done), 0);
    end

    // Random circles against the model, some partly off screen
    for (int n = 0; n < 6; n++) begin
      rc = 24'($urandom);
      applyStimulus(int'($urandom_range(0, 700)), int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 40)), rc, -1, cyc, wr, fa);
      @(negedge clk);
      checkOutput("rand_post_busy", int'(busy), 0);
    end

    // start held through the DONE cycle is only taken in the next IDLE cycle
    applyStimulus(50, 60, 2, 24'h111111, -1, cyc, wr, fa);
    buildModel(400, 300, 1);
    cx = 10'd400; cy = 9'd300; radius = 10'd1; color = 24'h222222;
    start = 1'b1;
    @(negedge clk);
    checkOutput("hold_idle_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_accept_busy", int'(busy), 1);
    drainCircle(24'h222222, -1, cyc, wr, fa);
    @(negedge clk);

    // Reset in the second iteration of a radius-10 circle
    buildModel(300, 200, 10);
    cx = 10'd300; cy = 9'd200; radius = 10'd10; color = 24'h0F0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_writing", int'(writing), 0);
    checkOutput("abort_done", int'(done), 0);
    dcount = 0; wcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      if (writing === 1'b1) wcount++;
    end
    checkOutput("abort_no_done", dcount, 0);
    checkOutput("abort_no_write", wcount, 0);
    applyStimulus(300, 200, 10, 24'h0F0F0F, -1, cyc, wr, fa);
    @(negedge clk);
    checkOutput("after_abort_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
